// File: rtl/vec_mul_pkg.sv
// Shared types and default configuration for the vector-multiply sequencer.
package vec_mul_pkg;

    localparam int DEF_MATRIX_SIZE  = 8;
    localparam int DEF_ADDRESSSIZE  = 10;
    localparam int DEF_WADDR_BW     = 2;
    localparam int PARTIAL_SUM_BW   = 20;
    localparam int DEF_SRAM_RD_LAT  = 1;
    localparam int DEF_ARRAY_LAT    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_WWAIT,
        ST_WAPPLY,
        ST_STREAM,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/vec_mul_seq_ctrl_valid_delay_line.sv
// Depth-configurable single-bit valid shift register with asynchronous active-low clear.
// All stages are exposed so the owner can see what is still in flight.
module valid_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    output logic             o_vld,
    output logic [DEPTH-1:0] o_taps
);

    logic [DEPTH-1:0] r_pipe;

    // Truncating the concatenation keeps the DEPTH==1 case free of negative slices.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= DEPTH'({r_pipe, i_vld});
        end
    end

    assign o_vld  = r_pipe[DEPTH-1];
    assign o_taps = r_pipe;

endmodule

// File: rtl/vec_mul_seq_ctrl.sv
// Job sequencer for the vector-multiply engine: weight load, UB streaming, result addressing.
// Optional VEC_MUL_PERF_CNT_EN adds a 32-bit busy-cycle counter output perf_cycles.
module vec_mul_seq_ctrl
    import vec_mul_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int WADDR_BW    = DEF_WADDR_BW,
    parameter int SRAM_RD_LAT = DEF_SRAM_RD_LAT,
    parameter int ARRAY_LAT   = DEF_ARRAY_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   reload_req,
    input  logic [WADDR_BW-1:0]    weight_sel,
    input  logic [ADDRESSSIZE-1:0] src_base,
    input  logic [ADDRESSSIZE-1:0] dst_base,
    input  logic [ADDRESSSIZE-1:0] vec_count,
    output logic                   wmem_rd_en,
    output logic [WADDR_BW-1:0]    wmem_rd_addr,
    output logic                   weight_reload,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_rd_addr,
    output logic                   res_wr_en,
    output logic [ADDRESSSIZE-1:0] res_wr_addr,
    output logic                   busy,
    output logic                   done
`ifdef VEC_MUL_PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int D  = SRAM_RD_LAT + ARRAY_LAT;
    localparam int CW = D + 1;
    // Chain positions two or more cycles away from producing a result write.
    localparam logic [CW-1:0] FAR_MASK  = CW'((2 ** (D - 1)) - 1);
    localparam logic [7:0]    WAIT_LAST = 8'((SRAM_RD_LAT > 1) ? (SRAM_RD_LAT - 2) : 0);

    if (D < 1 || SRAM_RD_LAT < 1 || MATRIX_SIZE < 1) begin : g_param_check
        $error("vec_mul_seq_ctrl: SRAM_RD_LAT and MATRIX_SIZE must be at least 1");
    end

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;

    logic [WADDR_BW-1:0]    r_wsel;
    logic [ADDRESSSIZE-1:0] r_src;
    logic [ADDRESSSIZE-1:0] r_dst;
    logic [ADDRESSSIZE-1:0] r_vec;
    logic [ADDRESSSIZE-1:0] r_iss_cnt;
    logic [ADDRESSSIZE-1:0] r_wr_cnt;
    logic [7:0]             r_wait_cnt;

    logic                   r_wmem_rd_en;
    logic [WADDR_BW-1:0]    r_wmem_rd_addr;
    logic                   r_weight_reload;
    logic                   r_ub_rd_en;
    logic [ADDRESSSIZE-1:0] r_ub_rd_addr;
    logic                   r_done;
    logic                   r_busy;

    logic                   w_res_wr_en;
    logic [D-1:0]           w_taps;
    logic [CW-1:0]          w_chain;
    logic                   w_drain_last;

    valid_delay_line #(
        .DEPTH (D)
    ) u_res_vld (
        .i_clk   (clk),
        .i_rst_n (rstn),
        .i_vld   (r_ub_rd_en),
        .o_vld   (w_res_wr_en),
        .o_taps  (w_taps)
    );

    // Outputs are registered, so FIN must be reached in the cycle of the final write.
    assign w_chain      = {w_taps, r_ub_rd_en};
    assign w_drain_last = ((w_chain & FAR_MASK) == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (reload_req) begin
                        w_next = ST_WLOAD;
                    end else if (vec_count != '0) begin
                        w_next = ST_STREAM;
                    end else begin
                        w_next = ST_FIN;
                    end
                end
            end
            ST_WLOAD: begin
                w_next = (SRAM_RD_LAT > 1) ? ST_WWAIT : ST_WAPPLY;
            end
            ST_WWAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_next = ST_WAPPLY;
                end
            end
            ST_WAPPLY: begin
                w_next = (r_vec != '0) ? ST_STREAM : ST_FIN;
            end
            ST_STREAM: begin
                if (r_iss_cnt == r_vec - 1'b1) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wsel     <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_vec      <= '0;
            r_iss_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wsel    <= weight_sel;
                r_src     <= src_base;
                r_dst     <= dst_base;
                r_vec     <= vec_count;
                r_iss_cnt <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (r_state == ST_STREAM) begin
                    r_iss_cnt <= r_iss_cnt + 1'b1;
                end
                if (w_res_wr_en) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            r_wait_cnt <= (r_state == ST_WWAIT) ? r_wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wmem_rd_en    <= 1'b0;
            r_wmem_rd_addr  <= '0;
            r_weight_reload <= 1'b0;
            r_ub_rd_en      <= 1'b0;
            r_ub_rd_addr    <= '0;
            r_done          <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_wmem_rd_en    <= (r_state == ST_WLOAD);
            r_weight_reload <= (r_state == ST_WAPPLY);
            r_ub_rd_en      <= (r_state == ST_STREAM);
            r_done          <= (r_state == ST_FIN);
            if (r_state == ST_WLOAD) begin
                r_wmem_rd_addr <= r_wsel;
            end
            if (r_state == ST_STREAM) begin
                r_ub_rd_addr <= r_src + r_iss_cnt;
            end
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_FIN) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef VEC_MUL_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if (r_busy) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

    assign wmem_rd_en    = r_wmem_rd_en;
    assign wmem_rd_addr  = r_wmem_rd_addr;
    assign weight_reload = r_weight_reload;
    assign ub_rd_en      = r_ub_rd_en;
    assign ub_rd_addr    = r_ub_rd_addr;
    assign res_wr_en     = w_res_wr_en;
    assign res_wr_addr   = r_dst + r_wr_cnt;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_vec_mul_seq_ctrl.sv
// Directed table-driven bench for vec_mul_seq_ctrl plus hand-written multi-cycle sequences.
module tb_vec_mul_seq_ctrl;

    localparam int AW = 10;
    localparam int WW = 2;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          reload_req;
    logic [WW-1:0] weight_sel;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW-1:0] vec_count;
    logic          wmem_rd_en;
    logic [WW-1:0] wmem_rd_addr;
    logic          weight_reload;
    logic          ub_rd_en;
    logic [AW-1:0] ub_rd_addr;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic          busy;
    logic          done;
`ifdef VEC_MUL_PERF_CNT_EN
    logic [31:0]   perf_cycles;
`endif

    vec_mul_seq_ctrl dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .reload_req    (reload_req),
        .weight_sel    (weight_sel),
        .src_base      (src_base),
        .dst_base      (dst_base),
        .vec_count     (vec_count),
        .wmem_rd_en    (wmem_rd_en),
        .wmem_rd_addr  (wmem_rd_addr),
        .weight_reload (weight_reload),
        .ub_rd_en      (ub_rd_en),
        .ub_rd_addr    (ub_rd_addr),
        .res_wr_en     (res_wr_en),
        .res_wr_addr   (res_wr_addr),
        .busy          (busy),
        .done          (done)
`ifdef VEC_MUL_PERF_CNT_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          reload;
        logic [WW-1:0] wsel;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] cnt;
        int            first_ub;
        int            done_cyc;
        int            busy_cyc;
    } vec_t;

    vec_t tbl [7];

    int n_chk  = 0;
    int n_fail = 0;

    int wmem_n, wmem_c, wmem_a, wrl_n, wrl_c;
    int ub_n, res_n, done_n, busy_n, rise_n;
    int ub_c [64];
    int ub_a [64];
    int res_c [64];
    int res_a [64];
    int done_c [8];
    int rise_c [8];
    logic busy_prev;
    int perf_at_done;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wmem_n = 0; wmem_c = 0; wmem_a = 0; wrl_n = 0; wrl_c = 0;
        ub_n = 0; res_n = 0; done_n = 0; busy_n = 0; rise_n = 0;
        busy_prev = 1'b0; perf_at_done = -1;
    endtask

    task automatic sample(input int n);
        if (wmem_rd_en) begin
            wmem_n++; wmem_c = n; wmem_a = int'(wmem_rd_addr);
        end
        if (weight_reload) begin
            wrl_n++; wrl_c = n;
        end
        if (ub_rd_en) begin
            if (ub_n < 64) begin
                ub_c[ub_n] = n; ub_a[ub_n] = int'(ub_rd_addr);
            end
            ub_n++;
        end
        if (res_wr_en) begin
            if (res_n < 64) begin
                res_c[res_n] = n; res_a[res_n] = int'(res_wr_addr);
            end
            res_n++;
        end
        if (done) begin
            if (done_n < 8) done_c[done_n] = n;
            done_n++;
`ifdef VEC_MUL_PERF_CNT_EN
            perf_at_done = int'(perf_cycles);
`endif
        end
        if (busy) busy_n++;
        if (busy && !busy_prev) begin
            if (rise_n < 8) rise_c[rise_n] = n;
            rise_n++;
        end
        busy_prev = busy;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        logic [AW-1:0] e;
        int            lim;
        clear_logs();
        reload_req = v.reload;
        weight_sel = v.wsel;
        src_base   = v.src;
        dst_base   = v.dst;
        vec_count  = v.cnt;
        start      = 1'b1;
        for (int n = 1; n <= v.done_cyc + 4; n++) begin
            @(negedge clk);
            sample(n);
            if (n == 1) start = 1'b0;
        end
        chk({tag, "_wmem_n"}, wmem_n, v.reload ? 1 : 0);
        chk({tag, "_wrl_n"}, wrl_n, v.reload ? 1 : 0);
        if (v.reload) begin
            chk({tag, "_wmem_cyc"}, wmem_c, 2);
            chk({tag, "_wmem_addr"}, wmem_a, int'(v.wsel));
            chk({tag, "_wrl_cyc"}, wrl_c, 3);
        end
        chk({tag, "_ub_n"}, ub_n, int'(v.cnt));
        chk({tag, "_res_n"}, res_n, int'(v.cnt));
        lim = (ub_n < int'(v.cnt)) ? ub_n : int'(v.cnt);
        for (int i = 0; i < lim && i < 64; i++) begin
            e = v.src + AW'(i);
            chk($sformatf("%s_ub_addr%0d", tag, i), ub_a[i], int'(e));
            chk($sformatf("%s_ub_cyc%0d", tag, i), ub_c[i], v.first_ub + i);
        end
        lim = (res_n < int'(v.cnt)) ? res_n : int'(v.cnt);
        for (int k = 0; k < lim && k < 64; k++) begin
            e = v.dst + AW'(k);
            chk($sformatf("%s_res_addr%0d", tag, k), res_a[k], int'(e));
            chk($sformatf("%s_res_cyc%0d", tag, k), res_c[k], v.first_ub + k + D);
        end
        chk({tag, "_done_n"}, done_n, 1);
        if (done_n > 0) chk({tag, "_done_cyc"}, done_c[0], v.done_cyc);
        chk({tag, "_busy_n"}, busy_n, v.busy_cyc);
        if (rise_n > 0) chk({tag, "_busy_rise"}, rise_c[0], 1);
`ifdef VEC_MUL_PERF_CNT_EN
        chk({tag, "_perf_at_done"}, perf_at_done, v.busy_cyc);
        chk({tag, "_perf_hold"}, int'(perf_cycles), v.busy_cyc);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_wmem_en"}, int'(wmem_rd_en), 0);
        chk({tag, "_wmem_addr"}, int'(wmem_rd_addr), 0);
        chk({tag, "_wrl"}, int'(weight_reload), 0);
        chk({tag, "_ub_en"}, int'(ub_rd_en), 0);
        chk({tag, "_ub_addr"}, int'(ub_rd_addr), 0);
        chk({tag, "_res_en"}, int'(res_wr_en), 0);
        chk({tag, "_res_addr"}, int'(res_wr_addr), 0);
`ifdef VEC_MUL_PERF_CNT_EN
        chk({tag, "_perf"}, int'(perf_cycles), 0);
`endif
    endtask

    initial begin
        //           reload wsel  src      dst      cnt     first done busy
        tbl[0] = '{1'b1, 2'd2, 10'h010, 10'h040, 10'd3, 4, 10, 9};
        tbl[1] = '{1'b0, 2'd0, 10'h000, 10'h000, 10'd0, 0, 2, 1};
        tbl[2] = '{1'b0, 2'd0, 10'h3FE, 10'h3FF, 10'd3, 2, 8, 7};
        tbl[3] = '{1'b1, 2'd1, 10'h005, 10'h006, 10'd0, 0, 4, 3};
        tbl[4] = '{1'b0, 2'd3, 10'h020, 10'h100, 10'd1, 2, 6, 5};
        tbl[5] = '{1'b1, 2'd3, 10'h3FF, 10'h000, 10'd5, 4, 12, 11};
        tbl[6] = '{1'b0, 2'd0, 10'h050, 10'h060, 10'd2, 2, 7, 6};

        rstn = 1'b0; start = 1'b0; reload_req = 1'b0; weight_sel = '0;
        src_base = '0; dst_base = '0; vec_count = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            run_job(tbl[t], $sformatf("vec%0d", t));
        end

        // start held high across a whole job and beyond: two jobs, back to back
        clear_logs();
        reload_req = 1'b0; weight_sel = '0; src_base = 10'h000;
        dst_base = 10'h010; vec_count = 10'd2; start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            sample(n);
            if (n == 11) start = 1'b0;
        end
        chk("hold_done_n", done_n, 2);
        if (done_n >= 2) begin
            chk("hold_done0_cyc", done_c[0], 7);
            chk("hold_done1_cyc", done_c[1], 14);
        end
        chk("hold_rise_n", rise_n, 2);
        if (rise_n >= 2) chk("hold_rise1_cyc", rise_c[1], 8);
        chk("hold_ub_n", ub_n, 4);
        chk("hold_res_n", res_n, 4);
        if (res_n >= 4) begin
            chk("hold_res_addr0", res_a[0], 16);
            chk("hold_res_addr1", res_a[1], 17);
            chk("hold_res_addr2", res_a[2], 16);
            chk("hold_res_addr3", res_a[3], 17);
        end

        // asynchronous reset in the middle of streaming
        clear_logs();
        reload_req = 1'b0; src_base = 10'h050; dst_base = 10'h060;
        vec_count = 10'd6; start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            sample(n);
            if (n == 1) start = 1'b0;
        end
        chk("abort_ub_before", ub_n, 2);
        rstn = 1'b0;
        #1;
        chk_all_zero("abort");
        clear_logs();
        repeat (2) begin
            @(negedge clk);
            sample(0);
        end
        rstn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            sample(n);
        end
        chk("abort_res_n", res_n, 0);
        chk("abort_done_n", done_n, 0);
        chk("abort_busy_n", busy_n, 0);
        run_job(tbl[6], "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mul_seq_ctrl.md
Name: vec_mul_seq_ctrl

Overview:
Parametrised sequencer for the vector-multiply engine; replaces the fixed free-running state machine and result-address counter.
- Per job: optionally loads one weight set from weight memory into the PE array, then streams vec_count input vectors from the unified buffer.
- Writes each result vector to the result buffer at an incrementing address, then pulses done.
- Owns all addressing and latency tracking; the MAC array and SRAMs stay external.

Parameters:
MATRIX_SIZE, 8, PE rows/cols; informational only, drives no logic
ADDRESSSIZE, 10, UB and result-buffer address width
WADDR_BW, 2, weight-memory address width
SRAM_RD_LAT, 1, cycles from rd_en to read data valid (UB and weight memory)
ARRAY_LAT, 2, cycles from data_in valid at array to result valid

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  job start, sampled in IDLE only
reload_req  in  1  load weights before streaming; sampled with start
weight_sel  in  WADDR_BW  weight-memory slot; sampled with start
src_base  in  ADDRESSSIZE  first UB address; sampled with start
dst_base  in  ADDRESSSIZE  first result-buffer address; sampled with start
vec_count  in  ADDRESSSIZE  vectors to process; sampled with start
wmem_rd_en  out  1  weight-memory read strobe
wmem_rd_addr  out  WADDR_BW  weight-memory address
weight_reload  out  1  one-cycle array weight-latch strobe
ub_rd_en  out  1  UB read strobe
ub_rd_addr  out  ADDRESSSIZE  UB address
res_wr_en  out  1  result-buffer write strobe
res_wr_addr  out  ADDRESSSIZE  result-buffer address
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; counters and valid pipe cleared. Asserting rstn mid-job aborts immediately; no done pulse.
- States: IDLE, WLOAD, WWAIT, WAPPLY, STREAM, DRAIN, FIN.
- IDLE + start: latch job inputs; busy=1 next cycle.
  - reload_req=1 -> WLOAD.
  - reload_req=0, vec_count!=0 -> STREAM.
  - reload_req=0, vec_count==0 -> FIN.
- WLOAD (1 cycle): wmem_rd_en=1, wmem_rd_addr=weight_sel -> WWAIT.
- WWAIT: hold SRAM_RD_LAT-1 cycles (0 cycles when SRAM_RD_LAT=1) -> WAPPLY.
- WAPPLY (1 cycle): weight_reload=1. vec_count!=0 -> STREAM; vec_count==0 -> FIN.
- STREAM: one read per cycle; ub_rd_en=1, ub_rd_addr=src_base+i for i=0..vec_count-1. Enters DRAIN after the last issue.
- Valid pipe: shift register of depth D=SRAM_RD_LAT+ARRAY_LAT, input ub_rd_en. Its output drives res_wr_en.
  - res_wr_en for vector i fires exactly D cycles after its ub_rd_en.
  - res_wr_addr=dst_base+k, k = count of prior writes in this job.
- DRAIN: exits when the valid pipe is empty -> FIN.
- FIN (1 cycle): done=1, busy=0 -> IDLE.
- start outside IDLE is ignored (including during FIN).
- Address arithmetic wraps modulo 2^ADDRESSSIZE; no error.
- vec_count=2^ADDRESSSIZE-1 is legal; the counter must not overflow its own width.

Optional Feature:
Macro VEC_MUL_PERF_CNT_EN.
- Defined: adds output perf_cycles (32 bit).
  - Clears on accepted start; increments every busy cycle; holds after done until next start.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package vec_mul_pkg: state enum, default widths (ADDRESSSIZE, WADDR_BW, PARTIAL_SUM_BW=20), latency constants.
- Sub-module valid_delay_line: parametrised depth-D single-bit shift register with async active-low clear. Instantiated for the result valid pipe.

Test Plan:
- reload_req=1, weight_sel=2, src_base=0x10, dst_base=0x40, vec_count=3 -> wmem_rd_addr=2 one cycle; weight_reload 1 cycle later; ub_rd_addr 0x10,0x11,0x12 consecutive; res_wr_addr 0x40..0x42 each 3 cycles after matching read; done once, cycle after last write.
- reload_req=0, vec_count=0 -> no wmem/UB/result strobes; done pulses 2 cycles after start; busy high exactly 1 cycle.
- src_base=0x3FE, dst_base=0x3FF, vec_count=3 -> UB reads 0x3FE,0x3FF,0x000; writes 0x3FF,0x000,0x001.
- start held high for the whole job plus 4 cycles -> exactly one job per accepted IDLE sample; second job begins the cycle after done.
- rstn low during STREAM after 2 issues -> all outputs 0 immediately; no further res_wr_en; no done; next start runs cleanly from dst_base.
- With VEC_MUL_PERF_CNT_EN, vec_count=5, reload_req=1 -> perf_cycles equals busy-high cycle count (reference model) and holds until next start.
